// File: rtl/bs_serve_arbiter.sv
// rtl/bs_serve_arbiter.sv - round-robin SERVE_REG scheduler between pricing modules and DataManager
//
// Shares one packet DataManager among BSMODS pricing modules. Pending module
// requests are arbitrated round-robin. The winner is presented one-hot on
// serve_reg until DataManager answers with the matching reg_en strobe. The
// module is then granted for one cycle and pkt_count advances.
//
// Optional feature macro: SERVE_WDOG_EN
//   When it is defined, a transaction left in WAIT for WDOG_CYCLES cycles is
//   aborted without a grant, and the sticky wdog_err flag is set.
//   When it is undefined, WAIT is held indefinitely, wdog_err is tied 0 and
//   err_clr has no effect.
//
// Parameters
//   BSMODS       number of pricing modules / request lines (>= 2)
//   WDOG_CYCLES  WAIT cycles before a watchdog abort (>= 8)
//   CNT_W        width of pkt_count
//
// Ports
//   clock        in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   req          in   level request per module, held until its grant pulse
//   out_of_data  in   DataManager OutOfData; 1 blocks new transactions
//   reg_en       in   DataManager regEn load strobe, one per module
//   serve_reg    out  one-hot SERVE_REG request to DataManager
//   grant        out  one-cycle one-hot pulse: module's packet was loaded
//   busy         out  1 while a transaction is outstanding
//   pkt_count    out  completed transactions, wraps
//   wdog_err     out  sticky watchdog abort flag
//   err_clr      in   synchronous clear of wdog_err

module bs_serve_arbiter #(
  parameter int BSMODS      = 2,
  parameter int WDOG_CYCLES = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [BSMODS-1:0] req,
  input  logic              out_of_data,
  input  logic [BSMODS-1:0] reg_en,
  output logic [BSMODS-1:0] serve_reg,
  output logic [BSMODS-1:0] grant,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_count,
  output logic              wdog_err,
  input  logic              err_clr
);

  localparam int PW = (BSMODS > 1) ? $clog2(BSMODS) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t            state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     win_next;
  logic [PW-1:0]     pick_idx;
  logic              pick_found;
  logic [BSMODS-1:0] qual;
  logic              hit;
  logic              wdog_fire;
  int                pos;

  // A module still shows req during its own grant cycle. Masking it with
  // grant stops that module from being picked again immediately.
  assign qual = req & ~grant;

  // Only the strobe of the module being served completes the transaction.
  assign hit = |(reg_en & serve_reg);

  // Round-robin pick: the first qualified request at or above rr_ptr,
  // wrapping from BSMODS-1 back to 0.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pos        = 0;
    for (int k = 0; k < BSMODS; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= BSMODS) begin
        pos = pos - BSMODS;
      end
      if (!pick_found && qual[PW'(pos)]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(pos);
      end
    end
  end

  // After a completed or aborted transaction, the pointer moves one past
  // the winner.
  assign win_next = (win_idx == PW'(BSMODS - 1)) ? '0 : win_idx + PW'(1);

`ifdef SERVE_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);

  logic [WW-1:0] wdog_cnt;

  // The fire condition becomes true on the WDOG_CYCLES-th WAIT cycle.
  // A matching strobe in that same cycle still wins.
  assign wdog_fire = (state == S_WAIT) && !hit &&
                     (wdog_cnt == WW'(WDOG_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      // The counter is held at 0 while IDLE, so every WAIT starts from 0.
      if (state == S_IDLE) begin
        wdog_cnt <= '0;
      end else if (!hit && !wdog_fire) begin
        wdog_cnt <= wdog_cnt + WW'(1);
      end

      // If the watchdog fires in the same cycle as err_clr, the set wins.
      if (wdog_fire) begin
        wdog_err <= 1'b1;
      end else if (err_clr) begin
        wdog_err <= 1'b0;
      end
    end
  end
`else
  logic unused_wdog;

  assign wdog_fire   = 1'b0;
  assign wdog_err    = 1'b0;
  assign unused_wdog = err_clr ^ (WDOG_CYCLES == 0);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      serve_reg <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      pkt_count <= '0;
      rr_ptr    <= '0;
      win_idx   <= '0;
    end else begin
      grant <= '0;
      case (state)
        S_IDLE: begin
          if (!out_of_data && pick_found) begin
            serve_reg <= BSMODS'(1) << pick_idx;
            win_idx   <= pick_idx;
            busy      <= 1'b1;
            state     <= S_WAIT;
          end else begin
            serve_reg <= '0;
          end
        end

        S_WAIT: begin
          // out_of_data and req changes are deliberately ignored here.
          // Once a transaction is issued, it runs until strobe or watchdog.
          if (hit) begin
            serve_reg <= '0;
            busy      <= 1'b0;
            grant     <= serve_reg;
            rr_ptr    <= win_next;
            pkt_count <= pkt_count + CNT_W'(1);
            state     <= S_IDLE;
          end else if (wdog_fire) begin
            serve_reg <= '0;
            busy      <= 1'b0;
            rr_ptr    <= win_next;
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          serve_reg <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bs_serve_arbiter.md
# bs_serve_arbiter

Round-robin scheduler sharing the single packet DataManager among BSMODS Black-Scholes pricing modules. It collects per-module "ready for packet" requests, presents exactly one one-hot SERVE_REG request to DataManager at a time, and watches for the matching regEn load strobe. When the strobe arrives it retires the transaction and pulses a grant back to the served module. It sits between the pricing-module array and DataManager and keeps a packet count for status readout.

## Interface
- BSMODS, 2: number of pricing modules / request lines (≥2).
- WDOG_CYCLES, 64: max cycles in WAIT before watchdog abort (≥8).
- CNT_W, 16: width of pkt_count.

- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  BSMODS  level request per module; held until its grant pulse.
- out_of_data  in  1  DataManager OutOfData; 1 = no packets available.
- reg_en  in  BSMODS  DataManager regEn load strobe, one cycle.
- serve_reg  out  BSMODS  one-hot request to DataManager SERVE_REG.
- grant  out  BSMODS  one-cycle one-hot pulse: module's packet loaded.
- busy  out  1  1 while a transaction is outstanding (state WAIT).
- pkt_count  out  CNT_W  completed transactions, wraps.
- wdog_err  out  1  sticky watchdog abort flag.
- err_clr  in  1  synchronous clear of wdog_err.

## Operation
- Reset values: serve_reg=0, grant=0, busy=0, pkt_count=0, wdog_err=0, rr_ptr=0, state=IDLE.
- States: IDLE, WAIT.
- IDLE: qualified requests q = req & ~grant. If out_of_data=0 and q≠0: winner = first set bit of q searching upward from rr_ptr, wrapping at BSMODS-1→0. Next cycle: serve_reg=onehot(winner), busy=1, state=WAIT. Otherwise stay, serve_reg=0.
- WAIT: serve_reg held constant. If (reg_en & serve_reg)≠0: next cycle serve_reg=0, busy=0, grant=onehot(winner) for one cycle, rr_ptr=(winner+1) mod BSMODS, pkt_count+=1 (wraps all-ones→0), state=IDLE.
- reg_en bits not matching serve_reg are ignored.
- out_of_data rising in WAIT is ignored; transaction completes normally.
- req dropped by winner in WAIT does not abort; grant still issued.
- Simultaneous requests: round-robin order only; no module served twice while another with req=1 waits.

## Timing
- Request to serve_reg: 1 cycle (req sampled at edge N, serve_reg high after edge N).
- reg_en to grant: 1 cycle; serve_reg low in the same cycle as grant.
- Back-to-back: with req held by another module, next serve_reg asserts the cycle after grant (IDLE lasts 1 cycle). Minimum transaction period = DataManager latency + 2 cycles.
- reset_n low mid-transaction: all outputs to reset values immediately; in-flight packet discarded, no grant.
- err_clr and a watchdog fire in the same cycle: set wins.

## Configuration
- SERVE_WDOG_EN defined: WAIT counter increments each WAIT cycle, clears on entering WAIT. Reaching WDOG_CYCLES without matching reg_en: serve_reg=0, busy=0, no grant, pkt_count unchanged, wdog_err=1 (sticky until err_clr), rr_ptr=(winner+1) mod BSMODS, state=IDLE.
- SERVE_WDOG_EN undefined: no counter; WAIT held indefinitely; wdog_err tied 0; err_clr ignored.

## Test plan
- Single request: req=2'b01, out_of_data=0; DataManager model returns reg_en=2'b01 seven cycles after serve_reg -> serve_reg=01 for 7 cycles, grant=01 one cycle, pkt_count=1, busy drops with grant.
- Fairness: req=2'b11 held throughout -> serve order 0,1,0,1; each grant pulse one-hot; pkt_count=4 after four transactions.
- Starvation gate: out_of_data=1, req=2'b10 for 20 cycles -> serve_reg stays 0; drop out_of_data -> serve_reg=10 next cycle.
- Wrong strobe: serve_reg=01, model drives reg_en=10 -> ignored, WAIT held; then reg_en=01 -> grant=01.
- Watchdog (SERVE_WDOG_EN, WDOG_CYCLES=8): no reg_en -> serve_reg drops after 8 WAIT cycles, wdog_err=1, no grant; err_clr=1 one cycle -> wdog_err=0. Without macro: serve_reg held 200 cycles, wdog_err=0.
- Reset mid-WAIT: reset_n low 3 cycles after serve_reg=01 -> serve_reg, busy, pkt_count, rr_ptr to 0; no grant after release; pkt_count wraps 0xFFFF→0 when preloaded via 65536 transactions (or forced).
